// File: rtl/window_loader.sv
// rtl/window_loader.sv - 16x16 search-window builder from a column-major 32-bit pixel stream
// Stages one 16-pixel column from 4 beats, shifts it into the window, presents windows to ncc.
module window_loader #(
  parameter int REGION_W   = 64,
  parameter int NUM_STRIPS = 49,
  localparam int XW = $clog2(REGION_W),
  localparam int YW = $clog2(NUM_STRIPS) + 1,
  localparam int CW = $clog2(REGION_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [15:0][15:0][7:0] window_data,
  output logic                   window_data_ready,
  input  logic                   done_with_window_data,
  output logic [XW-1:0]          win_x,
  output logic [YW-1:0]          win_y,
  output logic                   strip_done,
  output logic                   frame_done
);

  typedef enum logic {FILL, PRESENT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [15:0][15:0][7:0] r_window;
  logic [15:0][7:0]       r_col_buf;
  logic [1:0]             r_beat_c;
  logic                   r_col_full;
  logic [CW-1:0]          r_col_count;
  logic [XW-1:0]          r_win_x;
  logic [YW-1:0]          r_win_y;
  logic                   r_ready;
  logic                   r_strip_done;
  logic                   r_frame_done;

  logic                   w_accept;
  logic                   w_shift;
  logic                   w_present;
  logic                   w_retire;
  logic                   w_strip_end;
  logic [CW-1:0]          w_cnt_inc;

  assign pix_ready         = !r_col_full;
  assign w_accept          = pix_valid && !r_col_full;
  assign w_cnt_inc         = r_col_count + CW'(1);
  assign window_data       = r_window;
  assign window_data_ready = r_ready;
  assign win_x             = r_win_x;
  assign win_y             = r_win_y;
  assign strip_done        = r_strip_done;
  assign frame_done        = r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_present   = 1'b0;
    w_retire    = 1'b0;
    w_strip_end = 1'b0;
    case (r_state)
      FILL: begin
        // The first 15 columns of a strip only pre-fill; nothing is presented until 16 are in.
        if (r_col_full) begin
          w_shift = 1'b1;
          if (w_cnt_inc >= CW'(16)) begin
            w_present   = 1'b1;
            w_state_nxt = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (done_with_window_data) begin
          w_retire    = 1'b1;
          w_strip_end = (r_col_count == CW'(REGION_W));
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_window     <= '0;
      r_col_buf    <= '0;
      r_beat_c     <= '0;
      r_col_full   <= 1'b0;
      r_col_count  <= '0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_ready      <= 1'b0;
      r_strip_done <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_strip_done <= w_strip_end;
      r_frame_done <= w_strip_end && (r_win_y == YW'(NUM_STRIPS - 1));
      // Staging keeps filling while a window is presented, so the next column is ready at retire.
      if (w_accept) begin
        r_col_buf[{r_beat_c, 2'd0}] <= pix_in[31:24];
        r_col_buf[{r_beat_c, 2'd1}] <= pix_in[23:16];
        r_col_buf[{r_beat_c, 2'd2}] <= pix_in[15:8];
        r_col_buf[{r_beat_c, 2'd3}] <= pix_in[7:0];
        r_beat_c <= r_beat_c + 2'd1;
        if (r_beat_c == 2'd3) r_col_full <= 1'b1;
      end
      if (w_shift) begin
        for (int i = 0; i < 16; i++) begin
          for (int j = 0; j < 15; j++) r_window[i][j] <= r_window[i][j+1];
          r_window[i][15] <= r_col_buf[i];
        end
        r_col_full  <= 1'b0;
        r_col_count <= w_cnt_inc;
        if (w_present) begin
          r_ready <= 1'b1;
          r_win_x <= XW'(r_col_count - CW'(15));
        end
      end
      if (w_retire) begin
        r_ready <= 1'b0;
        // Window contents survive the strip change; the refill pushes the old strip out.
        if (w_strip_end) begin
          r_col_count <= '0;
          r_win_y     <= (r_win_y == YW'(NUM_STRIPS - 1)) ? '0 : r_win_y + YW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window_loader.sv
// tb/tb_window_loader.sv - directed scoreboard bench for window_loader
module tb_window_loader;
  localparam int RW = 18;
  localparam int NS = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [31:0]            pix_in = '0;
  logic                   pix_valid = 1'b0;
  logic                   pix_ready;
  logic [15:0][15:0][7:0] window_data;
  logic                   window_data_ready;
  logic                   done_with_window_data = 1'b0;
  logic [4:0]             win_x;
  logic [1:0]             win_y;
  logic                   strip_done;
  logic                   frame_done;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  window_loader #(.REGION_W(RW), .NUM_STRIPS(NS)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pix_in                (pix_in),
    .pix_valid             (pix_valid),
    .pix_ready             (pix_ready),
    .window_data           (window_data),
    .window_data_ready     (window_data_ready),
    .done_with_window_data (done_with_window_data),
    .win_x                 (win_x),
    .win_y                 (win_y),
    .strip_done            (strip_done),
    .frame_done            (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pix(input int s, input int c, input int i);
    return 8'((16 * c + i + 37 * s) & 255);
  endfunction

  function automatic logic [15:0][15:0][7:0] exp_win(input int s, input int x);
    logic [15:0][15:0][7:0] w;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) w[i][j] = pix(s, x + j, i);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_win(input string tag, input logic [15:0][15:0][7:0] want);
    int fi = 0;
    int fj = 0;
    bit found = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (!found && window_data[i][j] !== want[i][j]) begin
          found = 1; fi = i; fj = j;
        end
    tests++;
    assert (window_data === want) else begin
      fails++;
      $error("FAIL %s: window[%0d][%0d] observed %0h expected %0h",
             tag, fi, fj, window_data[fi][fj], want[fi][fj]);
    end
  endtask

  task automatic send_beat(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = w;
    while (!pix_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("beat_accept_timeout", 32'(pix_ready), 32'd1);
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  task automatic send_col(input int s, input int c);
    if (c >= 15) sb.push_back('{c - 15, s});
    for (int k = 0; k < 4; k++)
      send_beat({pix(s, c, 4*k), pix(s, c, 4*k+1), pix(s, c, 4*k+2), pix(s, c, 4*k+3)});
  endtask

  task automatic wait_window(input string tag);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!window_data_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(window_data_ready), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk_win({tag, "_data"}, exp_win(e.y, e.x));
    chk({tag, "_win_x"}, 32'(win_x), 32'(e.x));
    chk({tag, "_win_y"}, 32'(win_y), 32'(e.y));
  endtask

  task automatic retire(input string tag, input logic want_strip, input logic want_frame);
    @(negedge clk);
    done_with_window_data = 1'b1;
    @(posedge clk);
    #1 done_with_window_data = 1'b0;
    chk({tag, "_ready_low"}, 32'(window_data_ready), 32'd0);
    chk({tag, "_strip_done"}, 32'(strip_done), 32'(want_strip));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(want_frame));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(window_data_ready), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("rst_win_x", 32'(win_x), 32'd0);
    chk("rst_win_y", 32'(win_y), 32'd0);
    chk("rst_strip_done", 32'(strip_done), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk_win("rst_window", '0);
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 16; c++) send_col(0, c);
    chk("latency_not_yet", 32'(window_data_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_one_cycle", 32'(window_data_ready), 32'd1);
    wait_window("s0w0");

    repeat (5) @(posedge clk);
    #1;
    chk("hold_ready", 32'(window_data_ready), 32'd1);
    chk_win("hold_data", exp_win(0, 0));
    retire("s0r0", 1'b0, 1'b0);

    @(negedge clk);
    done_with_window_data = 1'b1;
    @(posedge clk);
    #1 done_with_window_data = 1'b0;
    chk("stray_done_ready", 32'(window_data_ready), 32'd0);
    chk("stray_done_pix_ready", 32'(pix_ready), 32'd1);
    @(negedge clk);
    pix_in = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("novalid_pix_ready", 32'(pix_ready), 32'd1);

    send_col(0, 16);
    wait_window("s0w1");

    send_col(0, 17);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_pix_ready", 32'(pix_ready), 32'd0);
    chk_win("bp_stable", exp_win(0, 1));
    chk("bp_win_x", 32'(win_x), 32'd1);
    pix_valid = 1'b0;
    retire("s0r1", 1'b0, 1'b0);
    wait_window("s0w2");
    retire("s0r2", 1'b1, 1'b0);
    chk("strip0_win_y", 32'(win_y), 32'd1);
    @(posedge clk);
    #1;
    chk("strip_done_pulse", 32'(strip_done), 32'd0);

    for (int c = 0; c < 15; c++) send_col(1, c);
    repeat (4) @(posedge clk);
    #1;
    chk("refill_no_present", 32'(window_data_ready), 32'd0);
    send_col(1, 15);
    wait_window("s1w0");
    retire("s1r0", 1'b0, 1'b0);
    send_col(1, 16);
    wait_window("s1w1");
    retire("s1r1", 1'b0, 1'b0);
    send_col(1, 17);
    wait_window("s1w2");
    retire("s1r2", 1'b1, 1'b1);
    chk("frame_win_y", 32'(win_y), 32'd0);
    @(posedge clk);
    #1;
    chk("frame_done_pulse", 32'(frame_done), 32'd0);

    for (int c = 0; c < 16; c++) send_col(0, c);
    wait_window("s2w0");
    send_col(0, 16);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(window_data_ready), 32'd0);
    chk("midrst_pix_ready", 32'(pix_ready), 32'd1);
    chk("midrst_win_x", 32'(win_x), 32'd0);
    chk("midrst_win_y", 32'(win_y), 32'd0);
    chk_win("midrst_window", '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
